// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin writeback arbiter and busy scoreboard for the register file
// Optional saturating A/B conflict counter under `RF_WB_CONFLICT_CNT_EN.
module rf_wb_arbiter #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 32,
  parameter int ZERO_REG_RO = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic [ADDR_W-1:0]   q_rs_addr,
  input  logic [ADDR_W-1:0]   q_rt_addr,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy_vec,
`ifdef RF_WB_CONFLICT_CNT_EN
  output logic [15:0]         conflict_cnt,
`endif
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   RdAddr,
  output logic [DATA_W-1:0]   RdData
);

  localparam bit ZERO_RO = (ZERO_REG_RO != 0);

  typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;

  grant_e              last_grant_q, last_grant_d;
  logic                reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                hs;
  logic                drop;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;

  always_comb begin
    a_ready = rst_n & a_valid & (~b_valid | (last_grant_q == GRANT_B));
    b_ready = rst_n & b_valid & (~a_valid | (last_grant_q == GRANT_A));
    hs       = a_ready | b_ready;
    win_addr = a_ready ? a_addr : b_addr;
    win_data = a_ready ? a_data : b_data;
    // A zero-register write still completes its handshake but is never issued.
    drop     = ZERO_RO && (win_addr == '0);

    last_grant_d = last_grant_q;
    if (a_ready) begin
      last_grant_d = GRANT_A;
    end else if (b_ready) begin
      last_grant_d = GRANT_B;
    end

    reg_write_d = hs & ~drop;
    rd_addr_d   = reg_write_d ? win_addr : rd_addr_q;
    rd_data_d   = reg_write_d ? win_data : rd_data_q;

    // Clear before set so a same-edge reservation stays outstanding.
    busy_d = busy_q;
    if (hs) begin
      busy_d[win_addr] = 1'b0;
    end
    if (rsv_valid) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (ZERO_RO) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_B;
      reg_write_q  <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      busy_q       <= busy_d;
    end
  end

  assign hazard   = busy_q[q_rs_addr] | busy_q[q_rt_addr];
  assign busy_vec = busy_q;
  assign RegWrite = reg_write_q;
  assign RdAddr   = rd_addr_q;
  assign RdData   = rd_data_q;

`ifdef RF_WB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (a_valid && b_valid && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter with a rule-level reference model
module tb_rf_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [AW-1:0] a_addr, b_addr, rsv_addr, q_rs_addr, q_rt_addr;
  logic [DW-1:0] a_data, b_data;
  logic          rsv_valid, hazard;
  logic [NR-1:0] busy_vec;
  logic          RegWrite;
  logic [AW-1:0] RdAddr;
  logic [DW-1:0] RdData;
`ifdef RF_WB_CONFLICT_CNT_EN
  logic [15:0]   conflict_cnt;
`endif

  always #5 clk = ~clk;

  rf_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .ZERO_REG_RO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .q_rs_addr(q_rs_addr), .q_rt_addr(q_rt_addr),
    .hazard(hazard), .busy_vec(busy_vec),
`ifdef RF_WB_CONFLICT_CNT_EN
    .conflict_cnt(conflict_cnt),
`endif
    .RegWrite(RegWrite), .RdAddr(RdAddr), .RdData(RdData)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  int            total = 0;
  int            bad = 0;
  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [NR-1:0] m_busy;
  bit            m_last_a;
  int            m_cc;
  logic [DW-1:0] rf_dut[NR];
  logic [DW-1:0] rf_ref[NR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register-file stand-in: captures on the falling edge, checks each issued write.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_write: got addr %0h data %0h expected no write", RdAddr, RdData);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(RdAddr), 64'(mon_e.addr));
        check("wr_data", 64'(RdData), 64'(mon_e.data));
      end
      rf_dut[RdAddr] = RdData;
    end
  end

  task automatic cycle(input bit rst, input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       input bit rv, input logic [AW-1:0] ra,
                       input logic [AW-1:0] qs, input logic [AW-1:0] qt,
                       output bit ga, output bit gb);
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    rst_n = !rst; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    rsv_valid = rv; rsv_addr = ra; q_rs_addr = qs; q_rt_addr = qt;
    #3;
    ga = !rst && av && (!bv || !m_last_a);
    gb = !rst && bv && (!av || m_last_a);
    check("a_ready", 64'(a_ready), 64'(ga));
    check("b_ready", 64'(b_ready), 64'(gb));
    if (!$isunknown(busy_vec) || !rst) begin
      check("busy_vec", 64'(busy_vec), 64'(m_busy));
      check("hazard", 64'(hazard), 64'(m_busy[qs] | m_busy[qt]));
`ifdef RF_WB_CONFLICT_CNT_EN
      check("conflict_cnt", 64'(conflict_cnt), 64'(m_cc));
`endif
    end
    @(posedge clk);
    if (rst) begin
      m_busy = '0; m_last_a = 1'b0; m_cc = 0;
    end else begin
      if (av && bv && m_cc < 65535) m_cc++;
      if (ga || gb) begin
        wa = ga ? aa : ba;
        wd = ga ? ad : bd;
        m_last_a = ga;
        m_busy[wa] = 1'b0;
        if (wa != 0) begin
          exp_q.push_back({wa, wd});
          rf_ref[wa] = wd;
        end
      end
      if (rv && ra != 0) m_busy[ra] = 1'b1;
    end
    #1;
    if (rst) begin
      check("rst_regwrite", 64'(RegWrite), 64'd0);
      check("rst_rdaddr", 64'(RdAddr), 64'd0);
      check("rst_rddata", 64'(RdData), 64'd0);
      check("rst_busy", 64'(busy_vec), 64'd0);
    end
  endtask

  task automatic idle(input int n);
    bit ga, gb;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
  endtask

  initial begin
    bit ga, gb;
    bit ap, bp;
    logic [AW-1:0] pa, pb;
    logic [DW-1:0] pda, pdb;
    for (int i = 0; i < NR; i++) begin
      rf_dut[i] = '0;
      rf_ref[i] = '0;
    end
    m_busy = '0; m_last_a = 1'b0; m_cc = 0;

    // Reset with active requests and a reservation pending.
    cycle(1, 1, 5'd4, 32'h55, 0, 0, 0, 1, 5'd5, 0, 0, ga, gb);
    cycle(1, 1, 5'd4, 32'h55, 0, 0, 0, 1, 5'd5, 0, 0, ga, gb);

    // Single writer; the register file holds the value after the N+1 falling edge.
    cycle(0, 1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, ga, gb);
    idle(1);
    check("rf3_after_write", 64'(rf_dut[3]), 64'hDEADBEEF);

    // Round-robin from reset: A, B, A, B.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
    for (int i = 0; i < 4; i++) cycle(0, 1, 5'd1, 32'd1, 1, 5'd2, 32'd2, 0, 0, 0, 0, ga, gb);
    idle(1);
`ifdef RF_WB_CONFLICT_CNT_EN
    check("conflict_cnt_4", 64'(conflict_cnt), 64'd4);
`endif

    // Scoreboard reserve and clear by B.
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, ga, gb);
    cycle(0, 0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 5'd7, 0, ga, gb);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, ga, gb);
    check("hazard_cleared", 64'(hazard), 64'd0);

    // Same-edge set and clear of register 9: set wins.
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, ga, gb);
    cycle(0, 1, 5'd9, 32'h99, 0, 0, 0, 1, 5'd9, 5'd9, 0, ga, gb);
    check("collision_busy9", 64'(busy_vec[9]), 64'd1);
    check("collision_rdaddr", 64'(RdAddr), 64'd9);

    // Zero register: handshake, no write, no busy, A becomes last grant.
    cycle(0, 1, 5'd0, 32'h1234, 0, 0, 0, 1, 5'd0, 0, 0, ga, gb);
    check("zero_no_write", 64'(RegWrite), 64'd0);
    check("zero_busy0", 64'(busy_vec[0]), 64'd0);
    cycle(0, 1, 5'd6, 32'h66, 1, 5'd8, 32'h88, 0, 0, 0, 0, ga, gb);
    check("zero_then_b_wins", 64'(gb), 64'd1);
    cycle(0, 1, 5'd6, 32'h66, 0, 0, 0, 0, 0, 0, 0, ga, gb);
    idle(1);
    check("rf0_unchanged", 64'(rf_dut[0]), 64'd0);

    // Randomized traffic honouring hold-until-ready.
    ap = 0; bp = 0; pa = '0; pb = '0; pda = '0; pdb = '0;
    for (int i = 0; i < 600; i++) begin
      if (!ap && $urandom_range(0, 3) != 0) begin
        ap = 1; pa = AW'($urandom_range(0, 15)); pda = $urandom;
      end
      if (!bp && $urandom_range(0, 3) != 0) begin
        bp = 1; pb = AW'($urandom_range(0, 15)); pdb = $urandom;
      end
      cycle(0, ap, pa, pda, bp, pb, pdb, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)),
            AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), ga, gb);
      if (ga) ap = 0;
      if (gb) bp = 0;
    end
    idle(3);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < NR; i++) check($sformatf("rf_final_%0d", i), 64'(rf_dut[i]), 64'(rf_ref[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
